// File: rtl/rd_bank_rr_arbiter.sv
// Per-bank round-robin read arbiter in front of the 8x8 read crossbar, with read-return tracking.
// Optional RD_ARB_PERF_CNT_EN adds saturating conflict and grant counters.
module rd_bank_rr_arbiter #(
  parameter int NUM_PORT = 8,
  parameter int SEL_W    = 3,
  parameter int RD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORT*(SEL_W+1)-1:0]   lsu_req_i,
  output logic [NUM_PORT*(SEL_W+1)-1:0]   xbar_req_o,
  output logic [NUM_PORT-1:0]             gnt_o,
  output logic [NUM_PORT-1:0]             rvalid_o,
  output logic [NUM_PORT*SEL_W-1:0]       rbank_o,
  output logic                            busy_o
`ifdef RD_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                     conflict_cnt_o,
  output logic [31:0]                     grant_cnt_o
`endif
);

  logic [SEL_W-1:0]          sel       [NUM_PORT];
  logic [NUM_PORT-1:0]       ren;
  logic [SEL_W-1:0]          ptr       [NUM_PORT];
  logic [SEL_W-1:0]          win       [NUM_PORT];
  logic [NUM_PORT-1:0]       bank_hit;
  logic [SEL_W-1:0]          idx;
  logic [NUM_PORT-1:0]       used;
  logic [SEL_W-1:0]          free_bank [NUM_PORT];
  logic [SEL_W:0]            nfree;
  logic [SEL_W:0]            k_ng;
  logic [NUM_PORT*SEL_W-1:0] gnt_bank;
  logic [NUM_PORT-1:0]       pipe_vld  [RD_LAT];
  logic [NUM_PORT*SEL_W-1:0] pipe_bank [RD_LAT];

  always_comb begin
    ren = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      sel[i] = lsu_req_i[i*(SEL_W+1)+1 +: SEL_W];
      ren[i] = lsu_req_i[i*(SEL_W+1)];
    end
  end

  // Scan each bank's ring downward from ptr+7 to ptr so the last match is the closest one at/after ptr.
  always_comb begin
    bank_hit = '0;
    gnt_o    = '0;
    idx      = '0;
    for (int b = 0; b < NUM_PORT; b++) begin
      win[b] = '0;
      for (int k = NUM_PORT - 1; k >= 0; k--) begin
        idx = ptr[b] + SEL_W'(k);
        if (ren[idx] && (sel[idx] == SEL_W'(b))) begin
          bank_hit[b] = 1'b1;
          win[b]      = idx;
        end
      end
    end
    if (!rst) begin
      for (int b = 0; b < NUM_PORT; b++) begin
        if (bank_hit[b]) gnt_o[win[b]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_PORT; b++) begin
      if (rst)              ptr[b] <= '0;
      else if (bank_hit[b]) ptr[b] <= win[b] + SEL_W'(1);
    end
  end

  // Losers are packed onto the unused banks in order, so the crossbar always sees a full permutation.
  always_comb begin
    used       = '0;
    nfree      = '0;
    k_ng       = '0;
    xbar_req_o = '0;
    for (int b = 0; b < NUM_PORT; b++) free_bank[b] = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (gnt_o[i]) used[sel[i]] = 1'b1;
    end
    for (int b = 0; b < NUM_PORT; b++) begin
      if (!used[b]) begin
        free_bank[nfree[SEL_W-1:0]] = SEL_W'(b);
        nfree = nfree + (SEL_W+1)'(1);
      end
    end
    for (int i = 0; i < NUM_PORT; i++) begin
      if (gnt_o[i]) begin
        xbar_req_o[i*(SEL_W+1) +: SEL_W+1] = {sel[i], 1'b1};
      end else begin
        xbar_req_o[i*(SEL_W+1) +: SEL_W+1] = {free_bank[k_ng[SEL_W-1:0]], 1'b0};
        k_ng = k_ng + (SEL_W+1)'(1);
      end
    end
  end

  always_comb begin
    gnt_bank = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (gnt_o[i]) gnt_bank[i*SEL_W +: SEL_W] = sel[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_vld[s]  <= '0;
        pipe_bank[s] <= '0;
      end
    end else begin
      pipe_vld[0]  <= gnt_o;
      pipe_bank[0] <= gnt_bank;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_bank[s] <= pipe_bank[s-1];
      end
    end
  end

  assign rvalid_o = pipe_vld[RD_LAT-1];
  assign rbank_o  = pipe_bank[RD_LAT-1];

  always_comb begin
    busy_o = 1'b0;
    for (int s = 0; s < RD_LAT; s++) busy_o = busy_o | (|pipe_vld[s]);
  end

`ifdef RD_ARB_PERF_CNT_EN
  logic [SEL_W:0] n_req;
  logic [SEL_W:0] n_gnt;
  logic [32:0]    conflict_sum;
  logic [32:0]    grant_sum;

  always_comb begin
    n_req        = (SEL_W+1)'($countones(ren & {NUM_PORT{~rst}}));
    n_gnt        = (SEL_W+1)'($countones(gnt_o));
    conflict_sum = {1'b0, conflict_cnt_o} + 33'(n_req - n_gnt);
    grant_sum    = {1'b0, grant_cnt_o} + 33'(n_gnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_o <= '0;
      grant_cnt_o    <= '0;
    end else begin
      conflict_cnt_o <= conflict_sum[32] ? 32'hFFFF_FFFF : conflict_sum[31:0];
      grant_cnt_o    <= grant_sum[32]    ? 32'hFFFF_FFFF : grant_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_rd_bank_rr_arbiter.sv
// Bench for rd_bank_rr_arbiter: one instance at RD_LAT=1 with a return scoreboard, one at RD_LAT=3.
module tb_rd_bank_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lsu_req = '0;

  logic [31:0] xbar_req_o, xbar3;
  logic [7:0]  gnt_o, gnt3, rvalid_o, rvalid3;
  logic [23:0] rbank_o, rbank3;
  logic        busy_o, busy3;
`ifdef RD_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_o, grant_cnt_o, conflict3, grant3;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  vld;
    logic [23:0] bank;
  } ret_t;
  ret_t exp_q[$];

  always #5 clk = ~clk;

  rd_bank_rr_arbiter #(.NUM_PORT(8), .SEL_W(3), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .lsu_req_i(lsu_req), .xbar_req_o(xbar_req_o), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rbank_o(rbank_o), .busy_o(busy_o)
`ifdef RD_ARB_PERF_CNT_EN
    , .conflict_cnt_o(conflict_cnt_o), .grant_cnt_o(grant_cnt_o)
`endif
  );

  rd_bank_rr_arbiter #(.NUM_PORT(8), .SEL_W(3), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .lsu_req_i(lsu_req), .xbar_req_o(xbar3), .gnt_o(gnt3),
    .rvalid_o(rvalid3), .rbank_o(rbank3), .busy_o(busy3)
`ifdef RD_ARB_PERF_CNT_EN
    , .conflict_cnt_o(conflict3), .grant_cnt_o(grant3)
`endif
  );

  function automatic logic [31:0] rq(input int lsu, input int bank);
    rq = '0;
    rq[lsu*4 +: 4] = {3'(bank), 1'b1};
  endfunction

  function automatic logic [31:0] xbar_exp(input logic [2:0] bk [8], input logic [7:0] renm);
    xbar_exp = '0;
    for (int i = 0; i < 8; i++) xbar_exp[i*4 +: 4] = {bk[i], renm[i]};
  endfunction

  // One cycle: check the return due now, drive the cycle, check grant and permutation, queue the return.
  task automatic do_cycle(input logic r, input logic [31:0] req, input logic [7:0] exp_gnt,
                          input string name);
    ret_t        e, pushed;
    logic [23:0] mask;
    logic [7:0]  seen;
    logic        ok;
    @(negedge clk);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    mask = '0;
    for (int i = 0; i < 8; i++) if (e.vld[i]) mask[i*3 +: 3] = 3'b111;
    tests++;
    if (rvalid_o !== e.vld) begin
      fails++;
      $display("FAIL %s rvalid: got %h want %h", name, rvalid_o, e.vld);
    end
    tests++;
    if ((rbank_o & mask) !== e.bank) begin
      fails++;
      $display("FAIL %s rbank: got %h want %h", name, rbank_o & mask, e.bank);
    end
    rst = r;
    lsu_req = req;
    #1;
    tests++;
    if (gnt_o !== exp_gnt) begin
      fails++;
      $display("FAIL %s gnt: got %h want %h", name, gnt_o, exp_gnt);
    end
    seen = '0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seen[xbar_req_o[i*4+1 +: 3]] = 1'b1;
      if (exp_gnt[i]) begin
        if (xbar_req_o[i*4 +: 4] !== {req[i*4+1 +: 3], 1'b1}) ok = 1'b0;
      end else if (xbar_req_o[i*4] !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (seen !== 8'hFF || !ok) begin
      fails++;
      $display("FAIL %s xbar_perm: got %h banks_seen %h", name, xbar_req_o, seen);
    end
    pushed.vld  = exp_gnt;
    pushed.bank = '0;
    for (int i = 0; i < 8; i++) if (exp_gnt[i]) pushed.bank[i*3 +: 3] = req[i*4+1 +: 3];
    exp_q.push_back(pushed);
  endtask

  task automatic test_reset();
    logic [31:0] all0, ident;
    all0 = '0;
    ident = '0;
    for (int i = 0; i < 8; i++) begin
      all0 = all0 | rq(i, 0);
      ident[i*4 +: 4] = {3'(i), 1'b0};
    end
    for (int c = 0; c < 2; c++) begin
      do_cycle(1'b1, all0, 8'h00, "reset");
      tests++;
      if (xbar_req_o !== ident) begin
        fails++;
        $display("FAIL reset_xbar: got %h want %h", xbar_req_o, ident);
      end
      tests++;
      if (busy_o !== 1'b0 || busy3 !== 1'b0 || rvalid3 !== 8'h00) begin
        fails++;
        $display("FAIL reset_busy: got %b/%b rv3 %h want 0/0 00", busy_o, busy3, rvalid3);
      end
    end
  endtask

  task automatic test_distinct();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | rq(i, 7 - i);
    do_cycle(1'b0, r, 8'hFF, "distinct");
    tests++;
    if (xbar_req_o !== r) begin
      fails++;
      $display("FAIL distinct_xbar: got %h want %h", xbar_req_o, r);
    end
    do_cycle(1'b0, '0, 8'h00, "distinct_ret");
  endtask

  task automatic test_round_robin();
    do_cycle(1'b1, '0, 8'h00, "rr_rst");
    do_cycle(1'b0, rq(2,3) | rq(5,3) | rq(7,3), 8'h04, "rr_c1");
    do_cycle(1'b0, rq(5,3) | rq(7,3),           8'h20, "rr_c2");
    do_cycle(1'b0, rq(7,3),                     8'h80, "rr_c3");
    do_cycle(1'b0, rq(0,3) | rq(2,3),           8'h01, "rr_wrap");
    do_cycle(1'b0, rq(2,3),                     8'h04, "rr_c5");
    do_cycle(1'b0, rq(1,5) | rq(3,5),           8'h02, "rr_alt1");
    do_cycle(1'b0, rq(1,5) | rq(3,5),           8'h08, "rr_alt2");
    do_cycle(1'b0, rq(1,5) | rq(3,5),           8'h02, "rr_alt3");
    do_cycle(1'b0, rq(1,5) | rq(3,5),           8'h08, "rr_alt4");
    do_cycle(1'b0, '0, 8'h00, "rr_idle");
  endtask

  task automatic test_permutation();
    logic [2:0]  bk [8];
    logic [31:0] ex;
    do_cycle(1'b1, '0, 8'h00, "perm_rst");
    do_cycle(1'b0, rq(6,1), 8'h40, "perm_single");
    bk = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd7};
    ex = xbar_exp(bk, 8'h40);
    tests++;
    if (xbar_req_o !== ex) begin
      fails++;
      $display("FAIL perm_single_xbar: got %h want %h", xbar_req_o, ex);
    end
    do_cycle(1'b0, rq(0,7) | rq(7,0), 8'h81, "perm_swap");
    bk = '{3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    ex = xbar_exp(bk, 8'h81);
    tests++;
    if (xbar_req_o !== ex) begin
      fails++;
      $display("FAIL perm_swap_xbar: got %h want %h", xbar_req_o, ex);
    end
    do_cycle(1'b0, rq(3,2) | rq(4,2), 8'h08, "perm_conflict");
    bk = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    ex = xbar_exp(bk, 8'h08);
    tests++;
    if (xbar_req_o !== ex) begin
      fails++;
      $display("FAIL perm_conflict_xbar: got %h want %h", xbar_req_o, ex);
    end
    do_cycle(1'b0, '0, 8'h00, "perm_idle");
  endtask

  task automatic test_withdraw();
    do_cycle(1'b1, '0, 8'h00, "wd_rst");
    do_cycle(1'b0, rq(0,4) | rq(1,4), 8'h01, "wd_first");
    do_cycle(1'b0, '0,                8'h00, "wd_drop");
    do_cycle(1'b0, '0,                8'h00, "wd_quiet");
    do_cycle(1'b0, rq(0,4) | rq(1,4), 8'h02, "wd_ptr_held");
    do_cycle(1'b0, '0, 8'h00, "wd_idle");
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) do_cycle(1'b0, rq(5,6), 8'h20, "b2b");
    do_cycle(1'b0, '0, 8'h00, "b2b_ret");
    do_cycle(1'b0, '0, 8'h00, "b2b_idle");
  endtask

  task automatic check_lat3(input logic [7:0] exp_rv, input logic exp_busy, input string name);
    tests++;
    if (rvalid3 !== exp_rv || busy3 !== exp_busy) begin
      fails++;
      $display("FAIL %s: rvalid3 %h busy3 %b want %h %b", name, rvalid3, busy3, exp_rv, exp_busy);
    end
  endtask

  task automatic test_latency3();
    do_cycle(1'b1, '0, 8'h00, "lat3_rst");
    do_cycle(1'b0, rq(4,2), 8'h10, "lat3_t");
    tests++;
    if (gnt3 !== 8'h10) begin
      fails++;
      $display("FAIL lat3_gnt: got %h want %h", gnt3, 8'h10);
    end
    do_cycle(1'b0, '0, 8'h00, "lat3_t1");
    check_lat3(8'h00, 1'b1, "lat3_t1");
    do_cycle(1'b0, '0, 8'h00, "lat3_t2");
    check_lat3(8'h00, 1'b1, "lat3_t2");
    do_cycle(1'b0, '0, 8'h00, "lat3_t3");
    check_lat3(8'h10, 1'b1, "lat3_t3");
    tests++;
    if (rbank3[12 +: 3] !== 3'd2) begin
      fails++;
      $display("FAIL lat3_rbank: got %0d want 2", rbank3[12 +: 3]);
    end
    do_cycle(1'b0, '0, 8'h00, "lat3_t4");
    check_lat3(8'h00, 1'b0, "lat3_t4");
    do_cycle(1'b0, rq(4,2), 8'h10, "lat3_rt");
    do_cycle(1'b0, '0, 8'h00, "lat3_rt1");
    check_lat3(8'h00, 1'b1, "lat3_rt1");
    do_cycle(1'b1, '0, 8'h00, "lat3_rt2");
    check_lat3(8'h00, 1'b1, "lat3_rt2");
    do_cycle(1'b0, '0, 8'h00, "lat3_rt3");
    check_lat3(8'h00, 1'b0, "lat3_rt3_discard");
    do_cycle(1'b0, '0, 8'h00, "lat3_rt4");
    check_lat3(8'h00, 1'b0, "lat3_rt4");
  endtask

`ifdef RD_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_cycle(1'b1, '0, 8'h00, "perf_rst");
    do_cycle(1'b0, rq(0,0) | rq(1,0) | rq(2,0) | rq(3,0), 8'h01, "perf_c1");
    do_cycle(1'b0, rq(1,0) | rq(2,0) | rq(3,0),           8'h02, "perf_c2");
    do_cycle(1'b0, rq(2,0) | rq(3,0),                     8'h04, "perf_c3");
    do_cycle(1'b0, rq(3,0),                               8'h08, "perf_c4");
    do_cycle(1'b0, '0, 8'h00, "perf_idle");
    tests++;
    if (conflict_cnt_o !== 32'd6 || conflict3 !== 32'd6) begin
      fails++;
      $display("FAIL perf_conflict: got %0d/%0d want 6", conflict_cnt_o, conflict3);
    end
    tests++;
    if (grant_cnt_o !== 32'd4 || grant3 !== 32'd4) begin
      fails++;
      $display("FAIL perf_grant: got %0d/%0d want 4", grant_cnt_o, grant3);
    end
    do_cycle(1'b1, '0, 8'h00, "perf_clr");
    do_cycle(1'b0, '0, 8'h00, "perf_clr_idle");
    tests++;
    if (conflict_cnt_o !== 32'd0 || grant_cnt_o !== 32'd0) begin
      fails++;
      $display("FAIL perf_clear: got %0d/%0d want 0/0", conflict_cnt_o, grant_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_distinct();
    test_round_robin();
    test_permutation();
    test_withdraw();
    test_back_to_back();
    test_latency3();
`ifdef RD_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    do_cycle(1'b0, '0, 8'h00, "drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rd_bank_rr_arbiter.md
Name: rd_bank_rr_arbiter

Overview:
- Per-bank round-robin read arbiter placed in front of the 8x8 read crossbar.
- Takes raw LSU read requests ({sel[2:0], Ren} per LSU) and grants at most one LSU per bank per cycle.
- Rewrites the crossbar request vector as a conflict-free permutation, so the crossbar's fixed highest-index priority never decides who wins.
- Tracks issued reads and returns a per-LSU read-valid after the bank read latency.

Parameters:
- NUM_PORT, 8, number of LSUs and banks; only 8 is supported.
- SEL_W, 3, bank select width.
- RD_LAT, 1, bank read latency in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lsu_req_i  in  NUM_PORT*(SEL_W+1)  raw requests; slice i = {sel_i, ren_i}.
- xbar_req_o  out  NUM_PORT*(SEL_W+1)  requests driven to the crossbar; slice i = {sel, ren}.
- gnt_o  out  NUM_PORT  per-LSU grant for this cycle (combinational).
- rvalid_o  out  NUM_PORT  read data for LSU i is valid on the crossbar this cycle.
- rbank_o  out  NUM_PORT*SEL_W  bank that supplied LSU i's data, valid when rvalid_o[i]=1.
- busy_o  out  1  any read is in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Requests:
  - An LSU requests when ren_i=1.
  - It must hold sel_i and ren_i stable until the cycle gnt_o[i]=1 is seen.
  - The request completes in that grant cycle. Dropping ren_i before grant is legal and means a withdrawn request.
- Arbitration, per bank b:
  - Candidates are the LSUs with ren_i=1 and sel_i=b.
  - Winner is the first candidate at or after ptr_b, searching upward with wrap 7 to 0.
  - gnt_o[winner]=1; all other candidates get gnt_o=0.
- Pointer update:
  - On each clock edge where bank b granted LSU w, ptr_b <= (w+1) mod 8.
  - Otherwise ptr_b holds.
  - Any one requester waits at most 7 cycles.
- Permutation output:
  - Granted LSU i: xbar slice i = {sel_i, 1}.
  - Non-granted LSUs, ascending index: the k-th one takes the k-th unused bank in ascending order, with ren=0.
  - Every bank index therefore appears exactly once across xbar_req_o, every cycle.
  - With no requests at all, xbar slice i = {i, 0}.
- Return tracking:
  - An RD_LAT-deep shift pipeline carries {gnt vector, granted bank per LSU}.
  - rvalid_o[i] rises exactly RD_LAT cycles after gnt_o[i]; rbank_o[i] then equals the granted sel.
  - Back-to-back grants to the same LSU give back-to-back rvalids.
- busy_o = OR of all pipeline valid bits.
- Reset values:
  - All ptr_b = 0.
  - Pipeline cleared: rvalid_o=0, rbank_o=0, busy_o=0.
  - While rst=1: gnt_o=0 and xbar slice i = {i, 0}.
  - Reset mid-read discards in-flight returns; no rvalid is emitted for them.
- Simultaneous events: a grant and a return for the same LSU in the same cycle are independent and both are visible.
- Boundary: all 8 LSUs targeting distinct banks are all granted in the same cycle, with zero conflict.

Optional Feature:
- Macro: RD_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs conflict_cnt_o[31:0] and grant_cnt_o[31:0].
  - conflict_cnt_o increments by the number of requesting-but-not-granted LSUs per cycle.
  - grant_cnt_o increments by popcount(gnt_o) per cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- After reset, LSUs 0..7 request banks 7..0 (LSU i -> bank 7-i) -> gnt_o=8'hFF, every xbar ren=1, rvalid_o=8'hFF one cycle later (RD_LAT=1), rbank_o[i]=7-i.
- LSUs 2, 5, 7 all request bank 3 and hold -> grants over 3 cycles go to 2, 5, 7. A new LSU 0 request then wins before LSU 2 (ptr_3=0 after wrap).
- LSU 6 requests bank 1, others idle -> xbar slices: 6 = {1,1}; 0..5 = {0,0},{2,0},{3,0},{4,0},{5,0},{6,0}; 7 = {7,0}. Every bank appears exactly once.
- RD_LAT=3, grant LSU 4 at cycle t -> rvalid_o[4] only at t+3, busy_o high t+1..t+3. Assert rst at t+2 -> no rvalid at t+3, busy_o=0.
- LSU 1 drops its request before grant -> no grant, no rvalid, pointer unchanged.
- With RD_ARB_PERF_CNT_EN: 4 LSUs hit bank 0 for 4 cycles -> conflict_cnt_o = 3+2+1+0 = 6, grant_cnt_o = 4.
